// File: rtl/rgb2ycbcr_pipe_if.sv
// Pixel bus: three colour channels plus line/frame-active syncs.
// No latency of its own; carries one pixel per clock.
// No backpressure: the consumer must accept every beat.
//
// Ports (signals): ch0_dat/ch1_dat/ch2_dat  colour channels (R/G/B or Y/Cb/Cr)
//                  hsync                     line active
//                  vsync                     frame active
interface rgb2ycbcr_pipe_if #(
    parameter int P_DATA_WIDTH = 8
);
    logic [P_DATA_WIDTH-1:0] ch0_dat;
    logic [P_DATA_WIDTH-1:0] ch1_dat;
    logic [P_DATA_WIDTH-1:0] ch2_dat;
    logic                    hsync;
    logic                    vsync;

    modport master (output ch0_dat, ch1_dat, ch2_dat, hsync, vsync);
    modport slave  (input  ch0_dat, ch1_dat, ch2_dat, hsync, vsync);
endinterface

// File: rtl/rgb2ycbcr_pipe.sv
// RGB to YCbCr / gray / bypass converter, BT.601 or BT.709, rounded and saturated.
// Fixed 4-cycle latency for data and syncs in every mode.
// No backpressure: one pixel accepted and produced every clock.
//
// Ports: i_clk, i_rst_n (async active-low)
//        pix_i      slave  bus: R/G/B on ch0/ch1/ch2, hsync, vsync
//        i_mode     0 gray, 1 YCbCr, 2/3 bypass (latched at frame start)
//        i_std      0 BT.601, 1 BT.709      (latched at frame start)
//        pix_o      master bus: Y/Cb/Cr (or gray, or R/G/B), hsync&vsync, vsync
//        o_cfg_mode, o_cfg_std  configuration currently applied
module rgb2ycbcr_pipe #(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_COEF_FRAC  = 10
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    rgb2ycbcr_pipe_if.slave         pix_i,
    input  logic [1:0]              i_mode,
    input  logic                    i_std,
    rgb2ycbcr_pipe_if.master        pix_o,
    output logic [1:0]              o_cfg_mode,
    output logic                    o_cfg_std
);
    localparam int DW = P_DATA_WIDTH;
    localparam int W  = P_DATA_WIDTH + 12;

    if (P_COEF_FRAC != 10) begin : g_chk_frac
        $error("rgb2ycbcr_pipe: P_COEF_FRAC must be 10");
    end
    if (P_DATA_WIDTH < 8 || P_DATA_WIDTH > 12) begin : g_chk_width
        $error("rgb2ycbcr_pipe: P_DATA_WIDTH must be in 8..12");
    end

    typedef logic signed [W-1:0]  acc_t;
    typedef logic        [DW-1:0] pix_t;
    typedef logic signed [11:0]   coef_t;

    localparam acc_t ROUND   = acc_t'(2 ** (P_COEF_FRAC - 1));
    localparam acc_t OFFSET  = acc_t'(2 ** (DW - 1));
    localparam acc_t PIX_MAX = acc_t'(2 ** DW - 1);

    // Row order Y, Cb, Cr; column order R, G, B.
    localparam coef_t C601 [9] = '{ 12'sd306,  12'sd601,  12'sd117,
                                   -12'sd173, -12'sd339,  12'sd512,
                                    12'sd512, -12'sd429, -12'sd83 };
    localparam coef_t C709 [9] = '{ 12'sd218,  12'sd732,  12'sd74,
                                   -12'sd117, -12'sd395,  12'sd512,
                                    12'sd512, -12'sd465, -12'sd47 };

    function automatic acc_t mul(input pix_t x, input coef_t c);
        acc_t xe;
        acc_t ce;
        xe = acc_t'({1'b0, x});
        ce = acc_t'(c);
        return xe * ce;
    endfunction

    function automatic pix_t sat(input acc_t v);
        if (v[W-1])
            return '0;
        else if (v > PIX_MAX)
            return '1;
        else
            return v[DW-1:0];
    endfunction

    // Pipeline state. Index 0/1/2 of the rgb/out vectors = ch0/ch1/ch2.
    logic [2:0][DW-1:0] rgb0_d, rgb0_q, rgb1_d, rgb1_q, rgb2_d, rgb2_q, out_d, out_q;
    acc_t               prod_d [9];
    acc_t               prod_q [9];
    acc_t               sum_d  [3];
    acc_t               sum_q  [3];
    logic               hs0_q, vs0_q, hs1_q, vs1_q, hs2_q, vs2_q, hs3_q, vs3_q;
    logic               vld0, vld1, vld2;

    // Frame-start configuration latch.
    logic [1:0]         cfg_mode_d, cfg_mode_q;
    logic               cfg_std_d, cfg_std_q;
    logic               low_seen_d, low_seen_q;
    logic               vs_rise, std_eff;
    coef_t              coef [9];
    acc_t               y_sh, cb_sh, cr_sh;
    pix_t               y_px, cb_px, cr_px;

    assign vld0 = hs0_q & vs0_q;
    assign vld1 = hs1_q & vs1_q;
    assign vld2 = hs2_q & vs2_q;

    // A frame start only counts once vsync has been seen low since reset, so a
    // frame already running at reset release keeps the reset configuration.
    assign vs_rise = vs0_q & ~vs1_q & low_seen_q;

    always_comb begin
        low_seen_d = low_seen_q | ~pix_i.vsync;
        cfg_mode_d = cfg_mode_q;
        cfg_std_d  = cfg_std_q;
        if (vs_rise) begin
            cfg_mode_d = i_mode;
            cfg_std_d  = i_std;
        end
    end

    // The first pixel of a frame is multiplied in the same cycle the standard
    // is latched, so it must see the incoming value rather than the register.
    assign std_eff = vs_rise ? i_std : cfg_std_q;

    always_comb begin
        if (std_eff)
            coef = C709;
        else
            coef = C601;
    end

    always_comb begin
        // S0: register inputs, zeroed outside the active area
        rgb0_d = '0;
        if (pix_i.hsync && pix_i.vsync)
            rgb0_d = {pix_i.ch2_dat, pix_i.ch1_dat, pix_i.ch0_dat};

        // S1: nine products, plus bypass copy
        prod_d = '{default: '0};
        rgb1_d = '0;
        if (vld0) begin
            prod_d[0] = mul(rgb0_q[0], coef[0]);
            prod_d[1] = mul(rgb0_q[1], coef[1]);
            prod_d[2] = mul(rgb0_q[2], coef[2]);
            prod_d[3] = mul(rgb0_q[0], coef[3]);
            prod_d[4] = mul(rgb0_q[1], coef[4]);
            prod_d[5] = mul(rgb0_q[2], coef[5]);
            prod_d[6] = mul(rgb0_q[0], coef[6]);
            prod_d[7] = mul(rgb0_q[1], coef[7]);
            prod_d[8] = mul(rgb0_q[2], coef[8]);
            rgb1_d    = rgb0_q;
        end

        // S2: row sums with the half-LSB rounding term folded in
        sum_d  = '{default: '0};
        rgb2_d = '0;
        if (vld1) begin
            sum_d[0] = prod_q[0] + prod_q[1] + prod_q[2] + ROUND;
            sum_d[1] = prod_q[3] + prod_q[4] + prod_q[5] + ROUND;
            sum_d[2] = prod_q[6] + prod_q[7] + prod_q[8] + ROUND;
            rgb2_d   = rgb1_q;
        end

        // S3: floor shift, chroma offset, clamp, output mode select
        y_sh  = sum_q[0] >>> P_COEF_FRAC;
        cb_sh = sum_q[1] >>> P_COEF_FRAC;
        cr_sh = sum_q[2] >>> P_COEF_FRAC;
        y_px  = sat(y_sh);
        cb_px = sat(cb_sh + OFFSET);
        cr_px = sat(cr_sh + OFFSET);
        out_d = '0;
        if (vld2) begin
            case (cfg_mode_q)
                2'd0:    out_d = {y_px, y_px, y_px};
                2'd1:    out_d = {cr_px, cb_px, y_px};
                default: out_d = rgb2_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rgb0_q     <= '0;
            rgb1_q     <= '0;
            rgb2_q     <= '0;
            out_q      <= '0;
            prod_q     <= '{default: '0};
            sum_q      <= '{default: '0};
            hs0_q      <= 1'b0;
            vs0_q      <= 1'b0;
            hs1_q      <= 1'b0;
            vs1_q      <= 1'b0;
            hs2_q      <= 1'b0;
            vs2_q      <= 1'b0;
            hs3_q      <= 1'b0;
            vs3_q      <= 1'b0;
            cfg_mode_q <= 2'd1;
            cfg_std_q  <= 1'b0;
            low_seen_q <= 1'b0;
        end else begin
            rgb0_q     <= rgb0_d;
            rgb1_q     <= rgb1_d;
            rgb2_q     <= rgb2_d;
            out_q      <= out_d;
            prod_q     <= prod_d;
            sum_q      <= sum_d;
            hs0_q      <= pix_i.hsync;
            vs0_q      <= pix_i.vsync;
            hs1_q      <= hs0_q;
            vs1_q      <= vs0_q;
            hs2_q      <= hs1_q;
            vs2_q      <= vs1_q;
            hs3_q      <= hs2_q;
            vs3_q      <= vs2_q;
            cfg_mode_q <= cfg_mode_d;
            cfg_std_q  <= cfg_std_d;
            low_seen_q <= low_seen_d;
        end
    end

    assign pix_o.ch0_dat = out_q[0];
    assign pix_o.ch1_dat = out_q[1];
    assign pix_o.ch2_dat = out_q[2];
    assign pix_o.hsync   = hs3_q & vs3_q;
    assign pix_o.vsync   = vs3_q;
    assign o_cfg_mode    = cfg_mode_q;
    assign o_cfg_std     = cfg_std_q;
endmodule

// File: tb/tb_rgb2ycbcr_pipe.sv
// Directed and pseudo-random bench for rgb2ycbcr_pipe (8-bit and 10-bit instances).
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// The DUT has no backpressure, so every driven cycle has exactly one expected output.
module tb_rgb2ycbcr_pipe;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode;
    logic       std;
    logic [1:0] cfg_mode, cfg10_mode;
    logic       cfg_std, cfg10_std;
    int         n_checks = 0;
    int         n_pass   = 0;

    always #5 clk = ~clk;

    rgb2ycbcr_pipe_if #(.P_DATA_WIDTH(8))  in8  ();
    rgb2ycbcr_pipe_if #(.P_DATA_WIDTH(8))  out8 ();
    rgb2ycbcr_pipe_if #(.P_DATA_WIDTH(10)) in10 ();
    rgb2ycbcr_pipe_if #(.P_DATA_WIDTH(10)) out10 ();

    rgb2ycbcr_pipe #(.P_DATA_WIDTH(8), .P_COEF_FRAC(10)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .pix_i(in8), .i_mode(mode), .i_std(std),
        .pix_o(out8), .o_cfg_mode(cfg_mode), .o_cfg_std(cfg_std));

    rgb2ycbcr_pipe #(.P_DATA_WIDTH(10), .P_COEF_FRAC(10)) dut10 (
        .i_clk(clk), .i_rst_n(rst_n), .pix_i(in10), .i_mode(mode), .i_std(std),
        .pix_o(out10), .o_cfg_mode(cfg10_mode), .o_cfg_std(cfg10_std));

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
        logic       hs;
        logic       vs;
    } exp_t;

    exp_t exp_q[$];

    function automatic logic [7:0] sat8(input int v);
        if (v < 0)   return 8'd0;
        if (v > 255) return 8'd255;
        return 8'(v);
    endfunction

    function automatic exp_t golden(input logic [7:0] r, g, b, input logic hs, vs,
                                    input logic [1:0] m, input logic s);
        exp_t e;
        int   ri, gi, bi, y, cb, cr;
        e    = '0;
        e.vs = vs;
        e.hs = hs & vs;
        if (hs && vs) begin
            ri = int'(r);
            gi = int'(g);
            bi = int'(b);
            if (s) begin
                y  = ( 218 * ri + 732 * gi +  74 * bi + 512) >>> 10;
                cb = (-117 * ri - 395 * gi + 512 * bi + 512) >>> 10;
                cr = ( 512 * ri - 465 * gi -  47 * bi + 512) >>> 10;
            end else begin
                y  = ( 306 * ri + 601 * gi + 117 * bi + 512) >>> 10;
                cb = (-173 * ri - 339 * gi + 512 * bi + 512) >>> 10;
                cr = ( 512 * ri - 429 * gi -  83 * bi + 512) >>> 10;
            end
            case (m)
                2'd0: begin e.y = sat8(y); e.cb = sat8(y);        e.cr = sat8(y);        end
                2'd1: begin e.y = sat8(y); e.cb = sat8(cb + 128); e.cr = sat8(cr + 128); end
                default: begin e.y = r; e.cb = g; e.cr = b; end
            endcase
        end
        return e;
    endfunction

    task automatic set_px(input logic [7:0] r, g, b, input logic hs, vs);
        in8.ch0_dat = r;
        in8.ch1_dat = g;
        in8.ch2_dat = b;
        in8.hsync   = hs;
        in8.vsync   = vs;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mode  = 2'd1;
        std   = 1'b0;
        set_px(8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        in10.ch0_dat = '0; in10.ch1_dat = '0; in10.ch2_dat = '0;
        in10.hsync = 1'b0; in10.vsync = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({out8.ch0_dat, out8.ch1_dat, out8.ch2_dat, out8.hsync, out8.vsync, cfg_mode, cfg_std}
            !== {24'd0, 1'b0, 1'b0, 2'd1, 1'b0})
            $display("FAIL reset_state: got y=%0d cb=%0d cr=%0d hs=%0b vs=%0b mode=%0d std=%0b, want 0 0 0 0 0 1 0",
                     out8.ch0_dat, out8.ch1_dat, out8.ch2_dat, out8.hsync, out8.vsync, cfg_mode, cfg_std);
        else n_pass++;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({out8.ch0_dat, out8.ch1_dat, out8.ch2_dat, out8.hsync, out8.vsync, cfg_mode, cfg_std}
            !== {24'd0, 1'b0, 1'b0, 2'd1, 1'b0})
            $display("FAIL reset_release_idle: got y=%0d cb=%0d cr=%0d hs=%0b mode=%0d std=%0b, want 0 0 0 0 1 0",
                     out8.ch0_dat, out8.ch1_dat, out8.ch2_dat, out8.hsync, cfg_mode, cfg_std);
        else n_pass++;
    endtask

    task automatic test_ycbcr601();
        mode = 2'd1;
        std  = 1'b0;
        set_px(8'd255, 8'd255, 8'd255, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        n_checks++;
        if (out8.hsync !== 1'b0)
            $display("FAIL latency_not_early: got hs=%0b after 3 cycles, want 0", out8.hsync);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({out8.ch0_dat, out8.ch1_dat, out8.ch2_dat, out8.hsync} !== {8'd255, 8'd128, 8'd128, 1'b1})
            $display("FAIL white_601: got %0d/%0d/%0d hs=%0b, want 255/128/128 hs=1",
                     out8.ch0_dat, out8.ch1_dat, out8.ch2_dat, out8.hsync);
        else n_pass++;
        set_px(8'd255, 8'd0, 8'd0, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        n_checks++;
        if ({out8.ch0_dat, out8.ch1_dat, out8.ch2_dat} !== {8'd76, 8'd85, 8'd255})
            $display("FAIL red_601_cr_sat: got %0d/%0d/%0d, want 76/85/255",
                     out8.ch0_dat, out8.ch1_dat, out8.ch2_dat);
        else n_pass++;
        set_px(8'd0, 8'd0, 8'd255, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        n_checks++;
        if ({out8.ch0_dat, out8.ch1_dat, out8.ch2_dat} !== {8'd29, 8'd255, 8'd107})
            $display("FAIL blue_601_cb_sat: got %0d/%0d/%0d, want 29/255/107",
                     out8.ch0_dat, out8.ch1_dat, out8.ch2_dat);
        else n_pass++;
        set_px(8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
    endtask

    task automatic test_gray709_mode_switch();
        mode = 2'd0;
        std  = 1'b1;
        set_px(8'd255, 8'd0, 8'd0, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        n_checks++;
        if ({out8.ch0_dat, out8.ch1_dat, out8.ch2_dat, cfg_mode, cfg_std} !== {8'd54, 8'd54, 8'd54, 2'd0, 1'b1})
            $display("FAIL gray_709: got %0d/%0d/%0d mode=%0d std=%0b, want 54/54/54 mode=0 std=1",
                     out8.ch0_dat, out8.ch1_dat, out8.ch2_dat, cfg_mode, cfg_std);
        else n_pass++;
        mode = 2'd2;
        repeat (6) @(negedge clk);
        n_checks++;
        if ({out8.ch0_dat, out8.ch1_dat, out8.ch2_dat, cfg_mode} !== {8'd54, 8'd54, 8'd54, 2'd0})
            $display("FAIL midframe_mode_ignored: got %0d/%0d/%0d mode=%0d, want 54/54/54 mode=0",
                     out8.ch0_dat, out8.ch1_dat, out8.ch2_dat, cfg_mode);
        else n_pass++;
        set_px(8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        set_px(8'd255, 8'd0, 8'd0, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        n_checks++;
        if ({out8.ch0_dat, out8.ch1_dat, out8.ch2_dat, cfg_mode} !== {8'd255, 8'd0, 8'd0, 2'd2})
            $display("FAIL bypass_next_frame: got %0d/%0d/%0d mode=%0d, want 255/0/0 mode=2",
                     out8.ch0_dat, out8.ch1_dat, out8.ch2_dat, cfg_mode);
        else n_pass++;
        set_px(8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
    endtask

    // One driven cycle: check the output owed from 4 cycles ago, then drive.
    task automatic rand_cycle(input logic hs, vs, input logic [1:0] fm, input logic fs);
        exp_t       e;
        logic [7:0] r, g, b;
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if ({out8.ch0_dat, out8.ch1_dat, out8.ch2_dat, out8.hsync, out8.vsync} !== e) begin
            if (n_checks - n_pass <= 20)
                $display("FAIL rand_pixel: got %0d/%0d/%0d hs=%0b vs=%0b, want %0d/%0d/%0d hs=%0b vs=%0b",
                         out8.ch0_dat, out8.ch1_dat, out8.ch2_dat, out8.hsync, out8.vsync,
                         e.y, e.cb, e.cr, e.hs, e.vs);
        end else n_pass++;
        r = 8'($urandom_range(0, 255));
        g = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        set_px(r, g, b, hs, vs);
        exp_q.push_back(golden(r, g, b, hs, vs, fm, fs));
    endtask

    task automatic test_random_frames();
        logic [1:0] fm;
        logic       fs;
        fm = 2'd1;
        fs = 1'b0;
        exp_q.delete();
        repeat (4) exp_q.push_back('0);
        for (int f = 0; f < 2; f++) begin
            fm   = (f == 0) ? 2'd1 : 2'($urandom_range(0, 3));
            fs   = 1'($urandom_range(0, 1));
            mode = fm;
            std  = fs;
            repeat (6) rand_cycle(1'($urandom_range(0, 1)), 1'b0, fm, fs);
            for (int ln = 0; ln < 4; ln++) begin
                repeat (10) rand_cycle(1'b0, 1'b1, fm, fs);
                rand_cycle(1'b1, 1'b1, fm, fs);
                repeat (9) rand_cycle(1'b0, 1'b1, fm, fs);
                repeat (640) rand_cycle(1'b1, 1'b1, fm, fs);
            end
        end
        repeat (8) rand_cycle(1'b0, 1'b0, fm, fs);
        set_px(8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_width10();
        mode = 2'd1;
        std  = 1'b0;
        in10.ch0_dat = 10'd1023; in10.ch1_dat = 10'd1023; in10.ch2_dat = 10'd1023;
        in10.hsync = 1'b1; in10.vsync = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({out10.ch0_dat, out10.ch1_dat, out10.ch2_dat, out10.hsync} !== {10'd1023, 10'd512, 10'd512, 1'b1})
            $display("FAIL white_10bit: got %0d/%0d/%0d hs=%0b, want 1023/512/512 hs=1",
                     out10.ch0_dat, out10.ch1_dat, out10.ch2_dat, out10.hsync);
        else n_pass++;
        in10.hsync = 1'b0; in10.vsync = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset_midline();
        mode = 2'd0;
        std  = 1'b1;
        set_px(8'd100, 8'd150, 8'd200, 1'b1, 1'b1);
        repeat (6) @(negedge clk);
        n_checks++;
        if ({out8.ch0_dat, out8.ch1_dat, out8.ch2_dat, out8.hsync, cfg_mode, cfg_std}
            !== {8'd143, 8'd143, 8'd143, 1'b1, 2'd0, 1'b1})
            $display("FAIL pre_reset_gray709: got %0d/%0d/%0d hs=%0b mode=%0d std=%0b, want 143/143/143 hs=1 mode=0 std=1",
                     out8.ch0_dat, out8.ch1_dat, out8.ch2_dat, out8.hsync, cfg_mode, cfg_std);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out8.ch0_dat, out8.ch1_dat, out8.ch2_dat, out8.hsync, out8.vsync, cfg_mode, cfg_std}
            !== {24'd0, 1'b0, 1'b0, 2'd1, 1'b0})
            $display("FAIL reset_immediate: got %0d/%0d/%0d hs=%0b vs=%0b mode=%0d std=%0b, want 0 0 0 0 0 1 0",
                     out8.ch0_dat, out8.ch1_dat, out8.ch2_dat, out8.hsync, out8.vsync, cfg_mode, cfg_std);
        else n_pass++;
        set_px(8'd255, 8'd255, 8'd255, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (out8.hsync !== 1'b0)
            $display("FAIL post_reset_not_early: got hs=%0b after 3 cycles, want 0", out8.hsync);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({out8.ch0_dat, out8.ch1_dat, out8.ch2_dat, out8.hsync, cfg_mode, cfg_std}
            !== {8'd255, 8'd128, 8'd128, 1'b1, 2'd1, 1'b0})
            $display("FAIL post_reset_first_pixel: got %0d/%0d/%0d hs=%0b mode=%0d std=%0b, want 255/128/128 hs=1 mode=1 std=0",
                     out8.ch0_dat, out8.ch1_dat, out8.ch2_dat, out8.hsync, cfg_mode, cfg_std);
        else n_pass++;
        set_px(8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_ycbcr601();
        test_gray709_mode_switch();
        test_random_frames();
        test_width10();
        test_reset_midline();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
